// File: rtl/clk_div_gen.sv
// ---------------------------------------------------------------------------
// clk_div_gen
// Programmable clock divider. It produces a divided clock (a 50% square wave
// or a single-cycle pulse), a terminal-count strobe, and a saturating count
// of terminal counts seen while busy is high. A new divisor can be loaded at
// runtime. It is held as pending and applied at the next period boundary, or
// on the next edge if the divider is paused.
//
// Ports
//   clk        : single clock; everything updates on its rising edge
//   rst        : synchronous, active-high reset
//   en         : divider count enable
//   busy       : qualifies clkcount increments
//   mode       : 0 = 50% toggle output, 1 = single-cycle pulse output
//   div_load   : request to load div_value
//   div_value  : requested divisor (must be >= 2)
//   clr_count  : synchronous clear of clkcount and sat
//   clk_div    : divided output (registered)
//   tick       : one-cycle strobe following each terminal count (registered)
//   clkcount   : number of terminal counts seen with busy high
//   sat        : sticky flag, clkcount has reached its maximum
//   load_ack   : one-cycle pulse, a new divisor was applied
//   load_err   : one-cycle pulse, a requested divisor was rejected
// ---------------------------------------------------------------------------
module clk_div_gen #(
  parameter int DIV_W       = 16,
  parameter int CNT_W       = 32,
  parameter int DEFAULT_DIV = 500
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             busy,
  input  logic             mode,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_value,
  input  logic             clr_count,
  output logic             clk_div,
  output logic             tick,
  output logic [CNT_W-1:0] clkcount,
  output logic             sat,
  output logic             load_ack,
  output logic             load_err
);

  localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] MIN_DIV = DIV_W'(2);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DIV_W-1:0] r_count;
  logic [DIV_W-1:0] r_divReg;
  logic [DIV_W-1:0] r_divShd;
  logic             r_pend;
  logic             r_clkDiv;
  logic             r_tick;
  logic [CNT_W-1:0] r_clkcount;
  logic             r_sat;
  logic             r_loadAck;
  logic             r_loadErr;

  logic w_loadOk;
  logic w_loadBad;
  logic w_term;
  logic w_apply;

  assign w_loadOk  = div_load && (div_value >= MIN_DIV);
  assign w_loadBad = div_load && (div_value <  MIN_DIV);
  assign w_term    = en && (r_count == (r_divReg - DIV_W'(1)));
  // A pending divisor is applied at a period boundary. If the divider is
  // paused, no boundary is coming, so it is applied on the next edge instead.
  assign w_apply   = r_pend && (w_term || !en);

  // Active and shadow divisors. The apply path reads the old shadow value,
  // so a valid load that lands on the same edge becomes the next pending one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_divReg <= DEF_DIV;
      r_divShd <= DEF_DIV;
      r_pend   <= 1'b0;
    end else begin
      if (w_apply) begin
        r_divReg <= r_divShd;
      end
      if (w_loadOk) begin
        r_divShd <= div_value;
        r_pend   <= 1'b1;
      end else if (w_apply) begin
        r_pend   <= 1'b0;
      end
    end
  end

  // Period counter. A divisor applied while paused restarts the period.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_apply && !en) begin
      r_count <= '0;
    end else if (w_term) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= r_count + DIV_W'(1);
    end
  end

  // Registered outputs. In toggle mode the current level is kept and flipped
  // on each terminal count, so a switch from pulse mode continues from
  // whatever level clk_div has at that moment.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clkDiv  <= 1'b0;
      r_tick    <= 1'b0;
      r_loadAck <= 1'b0;
      r_loadErr <= 1'b0;
    end else begin
      r_clkDiv  <= mode ? w_term : (r_clkDiv ^ w_term);
      r_tick    <= w_term;
      r_loadAck <= w_apply;
      r_loadErr <= w_loadBad;
    end
  end

  // Busy tick counter. It saturates at all-ones and raises the sticky flag
  // on reaching the maximum. A clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clkcount <= '0;
      r_sat      <= 1'b0;
    end else if (clr_count) begin
      r_clkcount <= '0;
      r_sat      <= 1'b0;
    end else if (w_term && busy && (r_clkcount != CNT_MAX)) begin
      r_clkcount <= r_clkcount + CNT_W'(1);
      if (r_clkcount == (CNT_MAX - CNT_W'(1))) begin
        r_sat <= 1'b1;
      end
    end
  end

  assign clk_div  = r_clkDiv;
  assign tick     = r_tick;
  assign clkcount = r_clkcount;
  assign sat      = r_sat;
  assign load_ack = r_loadAck;
  assign load_err = r_loadErr;

endmodule

// File: tb/tb_clk_div_gen.sv
// ---------------------------------------------------------------------------
// tb_clk_div_gen
// Directed bench for clk_div_gen built with DEFAULT_DIV=4 and CNT_W=3.
// Inputs change and outputs are sampled on the falling edge. "Edge k" means
// the k-th rising edge after the setup of a scenario.
// ---------------------------------------------------------------------------
module tb_clk_div_gen;

  localparam int DIV_W = 8;
  localparam int CNT_W = 3;

  logic             clk;
  logic             rst;
  logic             en;
  logic             busy;
  logic             mode;
  logic             div_load;
  logic [DIV_W-1:0] div_value;
  logic             clr_count;
  logic             clk_div;
  logic             tick;
  logic [CNT_W-1:0] clkcount;
  logic             sat;
  logic             load_ack;
  logic             load_err;

  int errCount;
  int checkCount;

  clk_div_gen #(
    .DIV_W(DIV_W),
    .CNT_W(CNT_W),
    .DEFAULT_DIV(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .busy(busy),
    .mode(mode),
    .div_load(div_load),
    .div_value(div_value),
    .clr_count(clr_count),
    .clk_div(clk_div),
    .tick(tick),
    .clkcount(clkcount),
    .sat(sat),
    .load_ack(load_ack),
    .load_err(load_err)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one full cycle, ending on a falling edge.
  task automatic stepCycle();
    @(negedge clk);
  endtask

  // Hold reset for two edges with all inputs idle, then release it.
  task automatic applyReset();
    rst       = 1'b1;
    en        = 1'b0;
    busy      = 1'b0;
    mode      = 1'b0;
    div_load  = 1'b0;
    div_value = '0;
    clr_count = 1'b0;
    stepCycle();
    stepCycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    en        = 1'b1;
    busy      = 1'b1;
    mode      = 1'b0;
    div_load  = 1'b0;
    div_value = '0;
    clr_count = 1'b0;
    stepCycle();
    stepCycle();
    checkCount++;
    if ({clk_div, tick, clkcount, sat, load_ack, load_err} !== 8'b0) begin
      errCount++;
      $display("[TB] FAIL reset_state got {clk_div,tick,clkcount,sat,ack,err}=%b want 00000000",
               {clk_div, tick, clkcount, sat, load_ack, load_err});
    end
    rst = 1'b0;
  endtask

  // Divide by 4: tick on every 4th edge, clk_div high 4 cycles, low 4 cycles.
  task automatic test_divide();
    logic expTick;
    logic expDiv;
    applyReset();
    en = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      stepCycle();
      expTick = (k % 4 == 0);
      expDiv  = ((k / 4) % 2) == 1;
      checkCount++;
      if (tick !== expTick || clk_div !== expDiv) begin
        errCount++;
        $display("[TB] FAIL divide edge=%0d got tick=%b clk_div=%b want tick=%b clk_div=%b",
                 k, tick, clk_div, expTick, expDiv);
      end
    end
    checkCount++;
    if (clkcount !== 3'd0) begin
      errCount++;
      $display("[TB] FAIL divide_nobusy got clkcount=%0d want 0", clkcount);
    end
  endtask

  // Pulse mode: clk_div follows tick. Then switch back to toggle mode while
  // clk_div is low; the next terminal count drives it high.
  task automatic test_mode();
    logic expDiv;
    applyReset();
    en   = 1'b1;
    mode = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      stepCycle();
      expDiv = (k % 4 == 0);
      checkCount++;
      if (clk_div !== expDiv || tick !== expDiv) begin
        errCount++;
        $display("[TB] FAIL pulse_mode edge=%0d got clk_div=%b tick=%b want %b",
                 k, clk_div, tick, expDiv);
      end
    end
    mode = 1'b0;
    for (int k = 10; k <= 16; k++) begin
      stepCycle();
      expDiv = (k >= 12) && (k < 16);
      checkCount++;
      if (clk_div !== expDiv) begin
        errCount++;
        $display("[TB] FAIL mode_switch edge=%0d got clk_div=%b want %b", k, clk_div, expDiv);
      end
    end
  endtask

  // Load 3 while count is 1: the old period still ends at edge 4, the ack
  // comes with that tick, and later ticks are at edges 7 and 10.
  task automatic test_load();
    logic expTick;
    logic expAck;
    logic expDiv;
    applyReset();
    en = 1'b1;
    stepCycle();
    div_load  = 1'b1;
    div_value = 8'd3;
    stepCycle();
    div_load  = 1'b0;
    for (int k = 3; k <= 10; k++) begin
      stepCycle();
      expTick = (k == 4) || (k == 7) || (k == 10);
      expAck  = (k == 4);
      expDiv  = (k >= 4 && k < 7) || (k >= 10);
      checkCount++;
      if (tick !== expTick || load_ack !== expAck || clk_div !== expDiv) begin
        errCount++;
        $display("[TB] FAIL load edge=%0d got tick=%b ack=%b clk_div=%b want tick=%b ack=%b clk_div=%b",
                 k, tick, load_ack, clk_div, expTick, expAck, expDiv);
      end
    end
  endtask

  // A load of 3 is pending when a load of 2 lands on the terminal edge. The 3
  // is applied at edge 4 and the 2 at edge 7, so the next tick is at edge 9.
  task automatic test_back_to_back();
    logic expTick;
    logic expAck;
    applyReset();
    en = 1'b1;
    stepCycle();
    div_load  = 1'b1;
    div_value = 8'd3;
    stepCycle();
    div_load  = 1'b0;
    stepCycle();
    div_load  = 1'b1;
    div_value = 8'd2;
    for (int k = 4; k <= 11; k++) begin
      stepCycle();
      div_load = 1'b0;
      expTick  = (k == 4) || (k == 7) || (k == 9) || (k == 11);
      expAck   = (k == 4) || (k == 7);
      checkCount++;
      if (tick !== expTick || load_ack !== expAck) begin
        errCount++;
        $display("[TB] FAIL back_to_back edge=%0d got tick=%b ack=%b want tick=%b ack=%b",
                 k, tick, load_ack, expTick, expAck);
      end
    end
  endtask

  // Load while paused at count 2: the divisor is applied on the next edge and
  // the count restarts, so after re-enabling the tick comes 3 edges later.
  task automatic test_load_paused();
    logic expTick;
    logic expAck;
    applyReset();
    en = 1'b1;
    stepCycle();
    stepCycle();
    en        = 1'b0;
    div_load  = 1'b1;
    div_value = 8'd3;
    stepCycle();
    div_load  = 1'b0;
    stepCycle();
    en = 1'b1;
    for (int k = 4; k <= 8; k++) begin
      if (k > 4) stepCycle();
      expTick = (k == 7);
      expAck  = (k == 4);
      checkCount++;
      if (tick !== expTick || load_ack !== expAck || clk_div !== (k >= 7)) begin
        errCount++;
        $display("[TB] FAIL load_paused edge=%0d got tick=%b ack=%b clk_div=%b want tick=%b ack=%b clk_div=%b",
                 k, tick, load_ack, clk_div, expTick, expAck, (k >= 7));
      end
    end
  endtask

  // Pausing for 5 cycles after the edge-5 count freezes everything. The
  // period resumes from count 1 and finishes at edge 13.
  task automatic test_pause();
    logic expTick;
    applyReset();
    en   = 1'b1;
    busy = 1'b1;
    repeat (5) stepCycle();
    en = 1'b0;
    for (int k = 6; k <= 10; k++) begin
      stepCycle();
      checkCount++;
      if (clk_div !== 1'b1 || clkcount !== 3'd1 || tick !== 1'b0) begin
        errCount++;
        $display("[TB] FAIL pause edge=%0d got clk_div=%b clkcount=%0d tick=%b want 1 1 0",
                 k, clk_div, clkcount, tick);
      end
    end
    en = 1'b1;
    for (int k = 11; k <= 13; k++) begin
      stepCycle();
      expTick = (k == 13);
      checkCount++;
      if (tick !== expTick || clk_div !== !expTick || clkcount !== (expTick ? 3'd2 : 3'd1)) begin
        errCount++;
        $display("[TB] FAIL resume edge=%0d got tick=%b clk_div=%b clkcount=%0d want tick=%b",
                 k, tick, clk_div, clkcount, expTick);
      end
    end
  endtask

  // Divisor values 1 and 0 are rejected, and the divisor stays 4.
  task automatic test_load_err();
    applyReset();
    en = 1'b1;
    stepCycle();
    div_load  = 1'b1;
    div_value = 8'd1;
    stepCycle();
    checkCount++;
    if (load_err !== 1'b1) begin
      errCount++;
      $display("[TB] FAIL load_err_1 got %b want 1", load_err);
    end
    div_value = 8'd0;
    stepCycle();
    checkCount++;
    if (load_err !== 1'b1) begin
      errCount++;
      $display("[TB] FAIL load_err_0 got %b want 1", load_err);
    end
    div_load = 1'b0;
    stepCycle();
    checkCount++;
    if (load_err !== 1'b0 || tick !== 1'b1 || load_ack !== 1'b0) begin
      errCount++;
      $display("[TB] FAIL load_err_clear got err=%b tick=%b ack=%b want 0 1 0", load_err, tick, load_ack);
    end
    repeat (3) stepCycle();
    checkCount++;
    if (tick !== 1'b0) begin
      errCount++;
      $display("[TB] FAIL keep_div edge7 got tick=%b want 0", tick);
    end
    stepCycle();
    checkCount++;
    if (tick !== 1'b1 || load_ack !== 1'b0) begin
      errCount++;
      $display("[TB] FAIL keep_div edge8 got tick=%b ack=%b want 1 0", tick, load_ack);
    end
  endtask

  // 10 busy ticks saturate the 3-bit counter at 7. A clear on a terminal edge
  // wins over the increment, and a clear between ticks also zeroes the counter.
  task automatic test_clkcount();
    applyReset();
    en   = 1'b1;
    busy = 1'b1;
    repeat (24) stepCycle();
    checkCount++;
    if (clkcount !== 3'd6 || sat !== 1'b0) begin
      errCount++;
      $display("[TB] FAIL count_6 got clkcount=%0d sat=%b want 6 0", clkcount, sat);
    end
    repeat (16) stepCycle();
    checkCount++;
    if (clkcount !== 3'd7 || sat !== 1'b1) begin
      errCount++;
      $display("[TB] FAIL saturate got clkcount=%0d sat=%b want 7 1", clkcount, sat);
    end
    repeat (3) stepCycle();
    clr_count = 1'b1;
    stepCycle();
    clr_count = 1'b0;
    checkCount++;
    if (clkcount !== 3'd0 || sat !== 1'b0 || tick !== 1'b1) begin
      errCount++;
      $display("[TB] FAIL clr_on_term got clkcount=%0d sat=%b tick=%b want 0 0 1", clkcount, sat, tick);
    end
    repeat (4) stepCycle();
    checkCount++;
    if (clkcount !== 3'd1 || sat !== 1'b0) begin
      errCount++;
      $display("[TB] FAIL count_after_clr got clkcount=%0d sat=%b want 1 0", clkcount, sat);
    end
    clr_count = 1'b1;
    stepCycle();
    clr_count = 1'b0;
    checkCount++;
    if (clkcount !== 3'd0 || sat !== 1'b0) begin
      errCount++;
      $display("[TB] FAIL clr got clkcount=%0d sat=%b want 0 0", clkcount, sat);
    end
  endtask

  // Reset while clk_div is high and a divisor of 2 is pending. All outputs
  // clear, and the next tick comes 4 edges after release.
  task automatic test_reset_pending();
    applyReset();
    en = 1'b1;
    repeat (4) stepCycle();
    div_load  = 1'b1;
    div_value = 8'd2;
    stepCycle();
    div_load  = 1'b0;
    checkCount++;
    if (clk_div !== 1'b1) begin
      errCount++;
      $display("[TB] FAIL pre_reset got clk_div=%b want 1", clk_div);
    end
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    checkCount++;
    if ({clk_div, tick, clkcount, sat, load_ack, load_err} !== 8'b0) begin
      errCount++;
      $display("[TB] FAIL reset_pending got {clk_div,tick,clkcount,sat,ack,err}=%b want 00000000",
               {clk_div, tick, clkcount, sat, load_ack, load_err});
    end
    for (int k = 1; k <= 4; k++) begin
      stepCycle();
      checkCount++;
      if (tick !== (k == 4) || load_ack !== 1'b0) begin
        errCount++;
        $display("[TB] FAIL discard_pending edge=%0d got tick=%b ack=%b want tick=%b ack=0",
                 k, tick, load_ack, (k == 4));
      end
    end
  endtask

  initial begin
    errCount   = 0;
    checkCount = 0;
    rst        = 1'b1;
    en         = 1'b0;
    busy       = 1'b0;
    mode       = 1'b0;
    div_load   = 1'b0;
    div_value  = '0;
    clr_count  = 1'b0;
    stepCycle();
    test_reset();
    test_divide();
    test_mode();
    test_load();
    test_back_to_back();
    test_load_paused();
    test_pause();
    test_load_err();
    test_clkcount();
    test_reset_pending();
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
